block_mem_arbiter: RTL

//  Shares the single 256-bit main-memory block port between I-cache refills and D-cache refills/writebacks.

---
 rtl/block_mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/block_mem_arbiter.sv
// Block memory arbiter: shares one block-wide memory port between I-cache
// refills and D-cache refills/writebacks. One transfer is in flight at a
// time. Contested grants alternate between the sides, every transfer is
// bounded by a timeout, and new I-side grants are held off while a syscall
// drain is in progress.
module block_mem_arbiter #(
    parameter int BLOCK_W  = 256,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    // I-cache side
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [BLOCK_W-1:0] i_rdata,
    output logic               i_done,
    // D-cache side
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic [BLOCK_W-1:0] d_rdata,
    output logic               d_done,
    // memory block port
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_blk_rd,
    output logic               mem_blk_wr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_rd_valid,
    input  logic               mem_wr_valid,
    // syscall drain and status
    input  logic               sys_req,
    output logic               sys_idle,
    output logic               timeout_err
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_DR,
        ST_BUSY_DW,
        ST_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last_d;     // side that won the most recent contested grant
    logic               r_side_d;     // side owning the current transfer (1 = D)
    logic               r_timeout;    // current transfer ended by timeout
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [BLOCK_W-1:0] r_mem_wdata;
    logic [BLOCK_W-1:0] r_i_rdata;
    logic [BLOCK_W-1:0] r_d_rdata;

    logic w_elig_i;
    logic w_elig_d;
    logic w_contend;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy_rd;
    logic w_busy_wr;
    logic w_valid;
    logic w_expire;

    // Grant selection: a lone eligible side wins; on contention, the side
    // that did not win the previous contested grant goes first.
    assign w_elig_i  = i_req & ~sys_req;
    assign w_elig_d  = d_req;
    assign w_contend = w_elig_i & w_elig_d;
    assign w_grant_i = (r_state == ST_IDLE) & w_elig_i & (~w_elig_d | r_last_d);
    assign w_grant_d = (r_state == ST_IDLE) & w_elig_d & (~w_elig_i | ~r_last_d);

    // Only the completion matching the transfer kind counts; the other is ignored.
    assign w_busy_rd = (r_state == ST_BUSY_I) | (r_state == ST_BUSY_DR);
    assign w_busy_wr = (r_state == ST_BUSY_DW);
    assign w_valid   = (w_busy_rd & mem_rd_valid) | (w_busy_wr & mem_wr_valid);
    assign w_expire  = (w_busy_rd | w_busy_wr) & ~w_valid & (r_wait_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_i)      w_next = ST_BUSY_I;
                else if (w_grant_d) w_next = d_we ? ST_BUSY_DW : ST_BUSY_DR;
            end
            ST_BUSY_I, ST_BUSY_DR, ST_BUSY_DW: begin
                if (w_valid || w_expire) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping: latch address/write data, owner, fairness and wait counter.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: the wide data registers are reset too, because every output must read 0 in reset.
        if (!RESET) begin
            r_last_d    <= 1'b1;
            r_side_d    <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_wait_cnt <= '0;
            r_side_d   <= w_grant_d;
            if (w_contend) r_last_d <= w_grant_d;
            if (w_grant_i) begin
                r_mem_addr <= i_addr;
            end else begin
                r_mem_addr <= d_addr;
                if (d_we) r_mem_wdata <= d_wdata;
            end
        end else if (w_busy_rd || w_busy_wr) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Completion: capture read data (or zero on timeout) for the owning side.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_timeout <= 1'b0;
        end else if (w_busy_rd && mem_rd_valid) begin
            r_timeout <= 1'b0;
            if (r_side_d) r_d_rdata <= mem_rdata;
            else          r_i_rdata <= mem_rdata;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
            if (r_side_d) r_d_rdata <= '0;
            else          r_i_rdata <= '0;
        end else if (w_valid) begin
            r_timeout <= 1'b0;
        end
    end

    // Outputs are decoded from registered state, so strobes drop on the edge leaving BUSY.
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_blk_rd  = w_busy_rd;
    assign mem_blk_wr  = w_busy_wr;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign i_done      = (r_state == ST_RESP) & ~r_side_d;
    assign d_done      = (r_state == ST_RESP) & r_side_d;
    assign timeout_err = (r_state == ST_RESP) & r_timeout;
    assign sys_idle    = sys_req & (r_state == ST_IDLE) & ~d_req;

endmodule
